// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared constants and state type for the serial link
package ser_pkg;

    localparam int unsigned SER_WIDTH     = 8;
    localparam logic [7:0]  SER_SYNC_WORD = 8'hA5;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_deserializer.sv
// rtl/ser_deserializer.sv - LSB-first serial receiver with sync-word alignment
module ser_deserializer
    import ser_pkg::*;
#(
    parameter int unsigned      WIDTH     = SER_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD = SER_SYNC_WORD
) (
    input  logic             clock_ser,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_in,
    input  logic             resync,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             locked,
    output logic             overrun
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] nxt;
    logic             byte_done;

    assign nxt       = {data_in, win[WIDTH-1:1]};
    // A resync on the completing edge abandons that frame along with the lock.
    assign byte_done = enable && !resync && (state == LOCKED) && (bit_cnt == LAST_CNT);
    assign locked    = (state == LOCKED);

    always_ff @(posedge clock_ser or negedge reset) begin
        if (!reset) begin
            state   <= HUNT;
            bit_cnt <= '0;
            win     <= '0;
        end else begin
            if (enable) begin
                win <= nxt;
            end
            if (resync) begin
                state   <= HUNT;
                bit_cnt <= '0;
            end else if (enable) begin
                case (state)
                    HUNT: begin
                        if (nxt == SYNC_WORD) begin
                            state   <= LOCKED;
                            bit_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        bit_cnt <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clock_ser or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (resync) begin
                overrun <= 1'b0;
            end
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= nxt;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
